// File: rtl/retire_pair_buffer_if.sv
// Retirement pairing bus.
// Carries both cores' retirement strobes and observations into the pair
// buffer, and the paired head observations out to the trace consumer.
//
// Handshake: pair_valid_o/pair_obs_*_o are driven by the buffer and, once
// pair_valid_o is high, hold stable until the consumer takes the pair.
// A transfer happens on every clock edge where pair_valid_o && pair_ready_i.
// pair_valid_o never depends combinationally on pair_ready_i.
//
// Modports:
//   master - retirement sources and consumer side (drives retire/obs/ready)
//   slave  - the pair buffer (drives pair_valid/pair_obs)
interface retire_pair_buffer_if #(
    parameter int OBS_W = 64
);
    logic             retire_1_i;
    logic [OBS_W-1:0] obs_1_i;
    logic             retire_2_i;
    logic [OBS_W-1:0] obs_2_i;
    logic             pair_valid_o;
    logic             pair_ready_i;
    logic [OBS_W-1:0] pair_obs_1_o;
    logic [OBS_W-1:0] pair_obs_2_o;

    modport master (
        output retire_1_i, obs_1_i, retire_2_i, obs_2_i, pair_ready_i,
        input  pair_valid_o, pair_obs_1_o, pair_obs_2_o
    );

    modport slave (
        input  retire_1_i, obs_1_i, retire_2_i, obs_2_i, pair_ready_i,
        output pair_valid_o, pair_obs_1_o, pair_obs_2_o
    );
endinterface

// File: rtl/retire_pair_buffer.sv
// Retirement pair buffer.
// Buffers each core's retirement observations in its own circular FIFO and
// presents them as lock-stepped pairs. Raises per-side stall requests to the
// clock gating when a FIFO fills, and at end of run reports whether the two
// retirement streams were of equal length.
//
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   bus (slave)     retire strobes/observations in, pair handshake out
//   finish_i        run finished, start draining
//   stall_1_o/2_o   side FIFO full
//   count_1_o/2_o   side FIFO occupancy
//   overflow_o      sticky: a retirement was dropped on a full FIFO
//   done_o          drain complete
//   unmatched_o     with done_o: unpaired entries remain
//   state_o         FSM state (0 RUN, 1 DRAIN, 2 DONE) for observation
module retire_pair_buffer #(
    parameter int DEPTH = 4,
    parameter int OBS_W = 64,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    retire_pair_buffer_if.slave bus,
    input  logic             finish_i,
    output logic             stall_1_o,
    output logic             stall_2_o,
    output logic [CNT_W-1:0] count_1_o,
    output logic [CNT_W-1:0] count_2_o,
    output logic             overflow_o,
    output logic             done_o,
    output logic             unmatched_o,
    output logic [1:0]       state_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    localparam logic [1:0] S_RUN   = 2'd0;
    localparam logic [1:0] S_DRAIN = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    // Index 0 is core 1, index 1 is core 2.
    logic [OBS_W-1:0] mem_q   [2][DEPTH];
    logic [PTR_W-1:0] head_q  [2];
    logic [PTR_W-1:0] tail_q  [2];
    logic [CNT_W-1:0] count_q [2];
    logic             overflow_q;
    logic [1:0]       state_q;

    logic             retire [2];
    logic [OBS_W-1:0] obs_in [2];
    logic             full   [2];
    logic             empty  [2];
    logic             push   [2];
    logic             accept [2];
    logic             drop   [2];
    logic             pair_valid;
    logic             pop;

    always_comb begin
        retire[0] = bus.retire_1_i;
        retire[1] = bus.retire_2_i;
        obs_in[0] = bus.obs_1_i;
        obs_in[1] = bus.obs_2_i;
        for (int s = 0; s < 2; s++) begin
            full[s]  = (count_q[s] == FULL_CNT);
            empty[s] = (count_q[s] == '0);
            // Retirements are only captured while running; DRAIN/DONE ignore them.
            push[s]  = retire[s] && (state_q == S_RUN);
        end
        // DONE freezes the buffer, so no pair is offered there.
        pair_valid = (state_q != S_DONE) && !empty[0] && !empty[1];
        pop        = pair_valid && bus.pair_ready_i;
        for (int s = 0; s < 2; s++) begin
            // A same-cycle pop frees the head slot, so a full side still accepts.
            accept[s] = push[s] && (!full[s] || pop);
            drop[s]   = push[s] && full[s] && !pop;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int s = 0; s < 2; s++) begin
                head_q[s]  <= '0;
                tail_q[s]  <= '0;
                count_q[s] <= '0;
                for (int e = 0; e < DEPTH; e++) begin
                    mem_q[s][e] <= '0;
                end
            end
            overflow_q <= 1'b0;
            state_q    <= S_RUN;
        end else begin
            for (int s = 0; s < 2; s++) begin
                if (accept[s]) begin
                    mem_q[s][tail_q[s]] <= obs_in[s];
                    tail_q[s]           <= tail_q[s] + 1'b1;
                end
                if (pop) begin
                    head_q[s] <= head_q[s] + 1'b1;
                end
                if (accept[s] && !pop) begin
                    count_q[s] <= count_q[s] + 1'b1;
                end else if (!accept[s] && pop) begin
                    count_q[s] <= count_q[s] - 1'b1;
                end
            end

            if (drop[0] || drop[1]) begin
                overflow_q <= 1'b1;
            end

            case (state_q)
                S_RUN: begin
                    if (finish_i) begin
                        state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // Drain ends once either side runs dry.
                    if (!pair_valid) begin
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    state_q <= S_DONE;
                end
                default: begin
                    state_q <= S_RUN;
                end
            endcase
        end
    end

    assign bus.pair_valid_o = pair_valid;
    assign bus.pair_obs_1_o = mem_q[0][head_q[0]];
    assign bus.pair_obs_2_o = mem_q[1][head_q[1]];

    assign stall_1_o   = full[0];
    assign stall_2_o   = full[1];
    assign count_1_o   = count_q[0];
    assign count_2_o   = count_q[1];
    assign overflow_o  = overflow_q;
    assign done_o      = (state_q == S_DONE);
    assign unmatched_o = (state_q == S_DONE) && (!empty[0] || !empty[1]);
    assign state_o     = state_q;
endmodule

// File: tb/tb_retire_pair_buffer.sv
// Directed testbench for retire_pair_buffer at DEPTH=4, OBS_W=64.
module tb_retire_pair_buffer;
    localparam int DEPTH = 4;
    localparam int OBS_W = 64;
    localparam int CNT_W = $clog2(DEPTH + 1);

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;
    logic finish;
    logic             stall_1, stall_2;
    logic [CNT_W-1:0] cnt_1, cnt_2;
    logic             overflow, done, unmatched;
    logic [1:0]       state;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [OBS_W-1:0] exp1_q[$];
    logic [OBS_W-1:0] exp2_q[$];

    retire_pair_buffer_if #(.OBS_W(OBS_W)) bus ();

    retire_pair_buffer #(.DEPTH(DEPTH), .OBS_W(OBS_W), .CNT_W(CNT_W)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .bus         (bus),
        .finish_i    (finish),
        .stall_1_o   (stall_1),
        .stall_2_o   (stall_2),
        .count_1_o   (cnt_1),
        .count_2_o   (cnt_2),
        .overflow_o  (overflow),
        .done_o      (done),
        .unmatched_o (unmatched),
        .state_o     (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r1, input logic [OBS_W-1:0] o1,
                         input logic r2, input logic [OBS_W-1:0] o2);
        bus.retire_1_i = r1;
        bus.obs_1_i    = o1;
        bus.retire_2_i = r2;
        bus.obs_2_i    = o2;
    endtask

    task automatic do_reset();
        drive(1'b0, '0, 1'b0, '0);
        bus.pair_ready_i = 1'b0;
        finish = 1'b0;
        rst_n  = 1'b0;
        #2;
        rst_n  = 1'b1;
        step();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n  = 1'b0;
        finish = 1'b0;
        bus.pair_ready_i = 1'b0;
        drive(1'b0, '0, 1'b0, '0);
        step();
        n_cmp++; if (bus.pair_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b exp 0", bus.pair_valid_o); end
        n_cmp++; if (bus.pair_obs_1_o !== 64'h0) begin n_fail++; $display("FAIL rst_obs1 got %h exp 0", bus.pair_obs_1_o); end
        n_cmp++; if (bus.pair_obs_2_o !== 64'h0) begin n_fail++; $display("FAIL rst_obs2 got %h exp 0", bus.pair_obs_2_o); end
        n_cmp++; if ({stall_1, stall_2} !== 2'b00) begin n_fail++; $display("FAIL rst_stall got %b exp 00", {stall_1, stall_2}); end
        n_cmp++; if ({cnt_1, cnt_2} !== 6'd0) begin n_fail++; $display("FAIL rst_counts got %0d/%0d exp 0/0", cnt_1, cnt_2); end
        n_cmp++; if ({overflow, done, unmatched} !== 3'b000) begin n_fail++; $display("FAIL rst_flags got %b exp 000", {overflow, done, unmatched}); end
        n_cmp++; if (state !== 2'd0) begin n_fail++; $display("FAIL rst_state got %0d exp 0", state); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic_pairs();
        logic [OBS_W-1:0] a;
        logic [OBS_W-1:0] b;
        do_reset();
        bus.pair_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a = 64'hA1 + 64'(i);
            b = 64'hB1 + 64'(i);
            drive(1'b1, a, 1'b1, b);
            step();
            n_cmp++; if (bus.pair_valid_o !== 1'b1) begin n_fail++; $display("FAIL basic_valid[%0d] got %b exp 1", i, bus.pair_valid_o); end
            n_cmp++; if (bus.pair_obs_1_o !== a || bus.pair_obs_2_o !== b) begin n_fail++; $display("FAIL basic_pair[%0d] got %h/%h exp %h/%h", i, bus.pair_obs_1_o, bus.pair_obs_2_o, a, b); end
            n_cmp++; if (cnt_1 !== 3'd1 || cnt_2 !== 3'd1) begin n_fail++; $display("FAIL basic_count[%0d] got %0d/%0d exp 1/1", i, cnt_1, cnt_2); end
        end
        drive(1'b0, '0, 1'b0, '0);
        step();
        n_cmp++; if (cnt_1 !== 3'd0 || cnt_2 !== 3'd0) begin n_fail++; $display("FAIL basic_empty got %0d/%0d exp 0/0", cnt_1, cnt_2); end
        n_cmp++; if (bus.pair_valid_o !== 1'b0) begin n_fail++; $display("FAIL basic_valid_end got %b exp 0", bus.pair_valid_o); end
    endtask

    task automatic test_stall();
        do_reset();
        bus.pair_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 64'h11 + 64'(i), 1'b0, '0);
            step();
        end
        drive(1'b0, '0, 1'b0, '0);
        n_cmp++; if (cnt_1 !== 3'd4) begin n_fail++; $display("FAIL stall_count1 got %0d exp 4", cnt_1); end
        n_cmp++; if (stall_1 !== 1'b1 || stall_2 !== 1'b0) begin n_fail++; $display("FAIL stall_flags got %b%b exp 10", stall_1, stall_2); end
        n_cmp++; if (bus.pair_valid_o !== 1'b0) begin n_fail++; $display("FAIL stall_valid got %b exp 0", bus.pair_valid_o); end
        drive(1'b0, '0, 1'b1, 64'h21);
        step();
        drive(1'b0, '0, 1'b0, '0);
        n_cmp++; if (bus.pair_valid_o !== 1'b1) begin n_fail++; $display("FAIL stall_pair_valid got %b exp 1", bus.pair_valid_o); end
        n_cmp++; if (bus.pair_obs_1_o !== 64'h11 || bus.pair_obs_2_o !== 64'h21) begin n_fail++; $display("FAIL stall_pair got %h/%h exp 11/21", bus.pair_obs_1_o, bus.pair_obs_2_o); end
        step();
        n_cmp++; if (cnt_1 !== 3'd3 || stall_1 !== 1'b0) begin n_fail++; $display("FAIL stall_after_pop got cnt %0d stall %b exp 3/0", cnt_1, stall_1); end
        n_cmp++; if (cnt_2 !== 3'd0) begin n_fail++; $display("FAIL stall_count2 got %0d exp 0", cnt_2); end
    endtask

    task automatic test_overflow();
        do_reset();
        bus.pair_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 64'h31 + 64'(i), 1'b0, '0);
            step();
        end
        drive(1'b0, '0, 1'b0, '0);
        n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set got %b exp 1", overflow); end
        n_cmp++; if (cnt_1 !== 3'd4) begin n_fail++; $display("FAIL ovf_count got %0d exp 4", cnt_1); end
        drive(1'b0, '0, 1'b1, 64'h61);
        step();
        drive(1'b0, '0, 1'b0, '0);
        step();
        n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got %b exp 1", overflow); end
        n_cmp++; if (bus.pair_obs_1_o !== 64'h31) begin n_fail++; $display("FAIL ovf_head got %h exp 31", bus.pair_obs_1_o); end
        // asynchronous reset in the middle of a cycle clears everything at once
        rst_n = 1'b0;
        #1;
        n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_reset got %b exp 0", overflow); end
        n_cmp++; if (cnt_1 !== 3'd0 || cnt_2 !== 3'd0 || bus.pair_obs_1_o !== 64'h0) begin n_fail++; $display("FAIL ovf_reset_state got %0d/%0d %h exp 0/0 0", cnt_1, cnt_2, bus.pair_obs_1_o); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_full_push_pop();
        do_reset();
        bus.pair_ready_i = 1'b0;
        drive(1'b1, 64'h41, 1'b1, 64'h51);
        step();
        for (int i = 1; i < 4; i++) begin
            drive(1'b1, 64'h41 + 64'(i), 1'b0, '0);
            step();
        end
        drive(1'b0, '0, 1'b0, '0);
        n_cmp++; if (cnt_1 !== 3'd4 || cnt_2 !== 3'd1 || bus.pair_valid_o !== 1'b1) begin n_fail++; $display("FAIL fpp_setup got %0d/%0d v%b exp 4/1 v1", cnt_1, cnt_2, bus.pair_valid_o); end
        bus.pair_ready_i = 1'b1;
        drive(1'b1, 64'h45, 1'b0, '0);
        step();
        drive(1'b0, '0, 1'b0, '0);
        bus.pair_ready_i = 1'b0;
        n_cmp++; if (cnt_1 !== 3'd4 || cnt_2 !== 3'd0) begin n_fail++; $display("FAIL fpp_count got %0d/%0d exp 4/0", cnt_1, cnt_2); end
        n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL fpp_overflow got %b exp 0", overflow); end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, '0, 1'b1, 64'h52 + 64'(i));
            step();
        end
        drive(1'b0, '0, 1'b0, '0);
        for (int k = 0; k < 4; k++) begin
            n_cmp++; if (bus.pair_obs_1_o !== 64'h42 + 64'(k) || bus.pair_obs_2_o !== 64'h52 + 64'(k)) begin n_fail++; $display("FAIL fpp_order[%0d] got %h/%h exp %h/%h", k, bus.pair_obs_1_o, bus.pair_obs_2_o, 64'h42 + 64'(k), 64'h52 + 64'(k)); end
            bus.pair_ready_i = 1'b1;
            step();
        end
        n_cmp++; if (cnt_1 !== 3'd0 || cnt_2 !== 3'd0) begin n_fail++; $display("FAIL fpp_drained got %0d/%0d exp 0/0", cnt_1, cnt_2); end
    endtask

    task automatic test_back_to_back_wrap();
        int got;
        got = 0;
        do_reset();
        exp1_q.delete();
        exp2_q.delete();
        for (int c = 0; c < 40 && got < 6; c++) begin
            if (c < 6) begin
                drive(1'b1, 64'h60 + 64'(c), 1'b1, 64'h70 + 64'(c));
                exp1_q.push_back(64'h60 + 64'(c));
                exp2_q.push_back(64'h70 + 64'(c));
                bus.pair_ready_i = (c % 2 == 0);
            end else begin
                drive(1'b0, '0, 1'b0, '0);
                bus.pair_ready_i = 1'b1;
            end
            if (bus.pair_valid_o && bus.pair_ready_i && exp1_q.size() > 0) begin
                n_cmp++; if (bus.pair_obs_1_o !== exp1_q[0] || bus.pair_obs_2_o !== exp2_q[0]) begin n_fail++; $display("FAIL wrap_pair[%0d] got %h/%h exp %h/%h", got, bus.pair_obs_1_o, bus.pair_obs_2_o, exp1_q[0], exp2_q[0]); end
                void'(exp1_q.pop_front());
                void'(exp2_q.pop_front());
                got++;
            end
            step();
        end
        drive(1'b0, '0, 1'b0, '0);
        n_cmp++; if (got !== 6) begin n_fail++; $display("FAIL wrap_delivered got %0d exp 6", got); end
        n_cmp++; if (overflow !== 1'b0 || cnt_1 !== 3'd0 || cnt_2 !== 3'd0) begin n_fail++; $display("FAIL wrap_end got ovf %b cnt %0d/%0d exp 0 0/0", overflow, cnt_1, cnt_2); end
    endtask

    task automatic test_drain_unmatched();
        do_reset();
        bus.pair_ready_i = 1'b1;
        drive(1'b1, 64'h81, 1'b1, 64'h91);
        step();
        drive(1'b1, 64'h82, 1'b1, 64'h92);
        n_cmp++; if (bus.pair_obs_1_o !== 64'h81 || bus.pair_obs_2_o !== 64'h91 || bus.pair_valid_o !== 1'b1) begin n_fail++; $display("FAIL drain_pair0 got %h/%h v%b exp 81/91 v1", bus.pair_obs_1_o, bus.pair_obs_2_o, bus.pair_valid_o); end
        step();
        drive(1'b1, 64'h83, 1'b0, '0);
        n_cmp++; if (bus.pair_obs_1_o !== 64'h82 || bus.pair_obs_2_o !== 64'h92 || bus.pair_valid_o !== 1'b1) begin n_fail++; $display("FAIL drain_pair1 got %h/%h v%b exp 82/92 v1", bus.pair_obs_1_o, bus.pair_obs_2_o, bus.pair_valid_o); end
        step();
        drive(1'b0, '0, 1'b0, '0);
        finish = 1'b1;
        step();
        finish = 1'b0;
        n_cmp++; if (state !== 2'd1 || done !== 1'b0) begin n_fail++; $display("FAIL drain_state got %0d done %b exp 1 0", state, done); end
        step();
        n_cmp++; if (done !== 1'b1 || unmatched !== 1'b1) begin n_fail++; $display("FAIL drain_done got %b%b exp 11", done, unmatched); end
        n_cmp++; if (cnt_1 !== 3'd1 || cnt_2 !== 3'd0 || bus.pair_valid_o !== 1'b0) begin n_fail++; $display("FAIL drain_counts got %0d/%0d v%b exp 1/0 v0", cnt_1, cnt_2, bus.pair_valid_o); end
        // DONE freezes everything and ignores further retirements and finish
        drive(1'b1, 64'hEE, 1'b1, 64'hEF);
        finish = 1'b1;
        step();
        step();
        drive(1'b0, '0, 1'b0, '0);
        finish = 1'b0;
        n_cmp++; if (cnt_1 !== 3'd1 || cnt_2 !== 3'd0 || overflow !== 1'b0 || done !== 1'b1) begin n_fail++; $display("FAIL done_frozen got %0d/%0d ovf %b done %b exp 1/0 0 1", cnt_1, cnt_2, overflow, done); end
        n_cmp++; if (bus.pair_obs_1_o !== 64'h83) begin n_fail++; $display("FAIL done_head got %h exp 83", bus.pair_obs_1_o); end
    endtask

    task automatic test_drain_matched();
        do_reset();
        bus.pair_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 64'hC1 + 64'(i), 1'b1, 64'hD1 + 64'(i));
            step();
        end
        drive(1'b0, '0, 1'b0, '0);
        finish = 1'b1;
        step();
        finish = 1'b0;
        // retirement during DRAIN is ignored without flagging overflow
        drive(1'b1, 64'hCC, 1'b0, '0);
        step();
        drive(1'b0, '0, 1'b0, '0);
        n_cmp++; if (done !== 1'b1 || unmatched !== 1'b0) begin n_fail++; $display("FAIL match_done got %b%b exp 10", done, unmatched); end
        n_cmp++; if (cnt_1 !== 3'd0 || cnt_2 !== 3'd0 || overflow !== 1'b0) begin n_fail++; $display("FAIL match_counts got %0d/%0d ovf %b exp 0/0 0", cnt_1, cnt_2, overflow); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_basic_pairs();
        test_stall();
        test_overflow();
        test_full_push_pop();
        test_back_to_back_wrap();
        test_drain_unmatched();
        test_drain_matched();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/retire_pair_buffer.md
Name: retire_pair_buffer

Overview:
- Sits between the two core instances' retirement outputs and the contract-trace consumer.
- Cores retire in different cycles because their clocks are gated independently. The block buffers each core's retirement observations in its own FIFO and presents them as lock-stepped pairs over a valid/ready handshake.
- Raises per-side stall requests to the clock-gating logic when a FIFO fills.
- At end of run, reports whether the two retirement streams had equal length.

Parameters:
- DEPTH, 4, entries per side FIFO; power of two, >= 2.
- OBS_W, 64, observation width; {retire_instr[31:0], result[31:0]} by default.
- CNT_W, $clog2(DEPTH+1), occupancy counter width.

Ports:
- clk_i  in  1  block clock.
- rst_ni  in  1  asynchronous active-low reset.
- retire_1_i  in  1  core 1 retires an instruction this cycle.
- obs_1_i  in  OBS_W  core 1 observation; valid when retire_1_i=1.
- retire_2_i  in  1  core 2 retire strobe.
- obs_2_i  in  OBS_W  core 2 observation.
- finish_i  in  1  run finished; no further retirements are expected.
- pair_valid_o  out  1  head pair is available.
- pair_ready_i  in  1  consumer accepts the head pair.
- pair_obs_1_o  out  OBS_W  core 1 head observation.
- pair_obs_2_o  out  OBS_W  core 2 head observation.
- stall_1_o  out  1  core 1 FIFO full; request to gate clock 1.
- stall_2_o  out  1  core 2 FIFO full.
- count_1_o  out  CNT_W  core 1 FIFO occupancy.
- count_2_o  out  CNT_W  core 2 FIFO occupancy.
- overflow_o  out  1  sticky: a retirement was dropped because its FIFO was full.
- done_o  out  1  drain complete.
- unmatched_o  out  1  valid with done_o: residual unpaired entries remain.

Behaviour:
- Reset (asynchronous, rst_ni=0): both FIFOs empty, pointers 0, counts 0, overflow_o=0, FSM=RUN.
  - Output values under reset: all outputs 0, data outputs 0.
  - Reset asserted mid-operation discards all contents immediately.
- Each side is an independent circular FIFO.
  - Pointers have width $clog2(DEPTH) and wrap modulo DEPTH.
  - The count is kept separately, so full (count==DEPTH) and empty (count==0) are unambiguous.
- Push: occurs on retire_x_i=1 while FSM=RUN.
  - The entry is written at the tail and becomes visible at the output the next cycle.
  - Write-to-pair_valid latency is 1 cycle.
  - There is no bypass.
- Pop: occurs on pair_valid_o && pair_ready_i.
  - Pops both FIFOs in the same cycle.
  - pair_valid_o = (count_1!=0) && (count_2!=0); combinational from registered state.
  - pair_obs_x_o = head entries, driven combinationally from storage.
  - Outputs hold stable while valid && !ready.
- Simultaneous push and pop on the same side:
  - Count is unchanged.
  - Allowed even when full; the pop frees the slot, so the push is accepted.
- Push to a full side without a same-cycle pop:
  - The observation is dropped and the count is unchanged.
  - overflow_o is set and stays set until reset.
- stall_x_o = (count_x==DEPTH), combinational. The upstream clock gating guarantees no push while stall is high, so overflow indicates a protocol violation.
- Occupancy never exceeds DEPTH. Counts are zero-extended to CNT_W.
- FSM:
  - RUN: pushes accepted. On finish_i=1 -> DRAIN; a push in the same cycle as finish_i is still accepted.
  - DRAIN: pushes ignored, without setting overflow. Pairing and popping continue normally. When pair_valid_o=0 (at least one side empty) -> DONE next cycle.
  - DONE: done_o=1 and unmatched_o=(count_1!=0)||(count_2!=0).
    - Counts and pair outputs are frozen, with pair_valid_o forced 0.
    - Holds until reset; finish_i is ignored.
- done_o and unmatched_o are registered from FSM state; both are 0 outside DONE.
- finish_i while in DRAIN has no effect.

Test Plan:
- Reset, then retire_1/retire_2 pulsed together 3 times with obs 0xA1..A3 / 0xB1..B3, pair_ready_i=1 -> 3 pairs (A1,B1),(A2,B2),(A3,B3), each pair_valid 1 cycle after its push; counts return to 0.
- Core 1 retires 4 entries with core 2 silent and pair_ready_i=1 -> count_1_o=4, stall_1_o=1, pair_valid_o=0. Core 2 then retires once -> pair (entry0_1, entry0_2), count_1_o=3, stall_1_o=0.
- Full side 1 (count 4), one retire_1_i pulse, no pop -> observation dropped, overflow_o=1, count_1_o=4. A further reset clears overflow_o.
- Full side 1 with a pair available, retire_1_i and pop in the same cycle -> count_1_o stays 4, overflow_o=0, new entry appears at the tail in order.
- Push 6 pairs with ready toggling 1/0 at DEPTH=4 -> order preserved across pointer wrap, no drops, all 6 pairs delivered.
- Core 1 pushes 3 and core 2 pushes 2, consumer ready, then finish_i -> 2 pairs delivered, DONE reached with done_o=1, unmatched_o=1, count_1_o=1. With equal pushes of 3/3, DONE gives unmatched_o=0.
